// File: rtl/frame_sequencer.sv
// Frame controller: credit-gates upstream pixels per line, locks mode per frame, counts output beats to done.
// Latency: gating is combinational; state, mode and busy update one cycle after their trigger.
// Backpressure: s_ready follows m_ready while a line credit is held; optional watchdog via FRAME_WATCHDOG_EN.
module frame_sequencer #(
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int PRIME_LINES = 4,
    parameter int OUT_COUNT   = IMG_W * IMG_H,
    parameter int WD_CYCLES   = 1048576
) (
    input  logic       axi_clk,
    input  logic       axi_reset_n,
    input  logic       i_start,
    input  logic [1:0] i_mode,
    output logic [1:0] o_mode,
    output logic       o_busy,
    output logic       o_done_intr,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    input  logic       m_ready,
    input  logic       i_line_intr,
    input  logic       i_out_valid,
    input  logic       i_out_ready,
    output logic       o_error
);
    localparam int PW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int LW = $clog2(IMG_H + 1);
    localparam int CW = $clog2(PRIME_LINES + 1);
    localparam int OW = $clog2(OUT_COUNT + 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_mode;
    logic          r_busy;
    logic [PW-1:0] r_pix_cnt;
    logic [LW-1:0] r_line_cnt;
    logic [CW-1:0] r_credits, w_cred_dec, w_cred_nxt;
    logic [OW-1:0] r_out_cnt, w_out_nxt;
    logic          w_gate, w_active, w_in_beat, w_out_beat, w_line_end, w_frame_end;
    logic          w_start, w_wd_trip;

    assign w_start     = (r_state == S_IDLE) && i_start;
    assign w_active    = (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_gate      = (r_state == S_FEED) && (r_credits != '0);
    assign m_valid     = s_valid & w_gate;
    assign s_ready     = m_ready & w_gate;
    assign m_data      = s_data;
    assign w_in_beat   = s_valid & s_ready;
    assign w_line_end  = w_in_beat && (r_pix_cnt == PW'(IMG_W - 1));
    assign w_frame_end = w_line_end && (r_line_cnt == LW'(IMG_H - 1));
    assign w_out_beat  = w_active && i_out_valid && i_out_ready;
    assign w_out_nxt   = (w_out_beat && (r_out_cnt != OW'(OUT_COUNT))) ? r_out_cnt + OW'(1) : r_out_cnt;

    // Consume first, then refill: a refill coinciding with a line end nets to zero even at the ceiling.
    assign w_cred_dec  = r_credits - CW'(w_line_end);
    assign w_cred_nxt  = (i_line_intr && w_active && (w_cred_dec != CW'(PRIME_LINES)))
                         ? w_cred_dec + CW'(1) : w_cred_dec;

    assign o_mode      = r_mode;
    assign o_busy      = r_busy;
    assign o_done_intr = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_FEED;
            S_FEED:  if (w_wd_trip) w_state_nxt = S_IDLE;
                     else if (w_frame_end) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_wd_trip) w_state_nxt = S_IDLE;
                     else if (w_out_nxt == OW'(OUT_COUNT)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_mode     <= 2'd0;
            r_credits  <= '0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_out_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_start) begin
                r_mode     <= i_mode;
                r_credits  <= CW'(PRIME_LINES);
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
                r_out_cnt  <= '0;
            end else begin
                r_credits <= w_cred_nxt;
                r_out_cnt <= w_out_nxt;
                if (w_in_beat) r_pix_cnt <= w_line_end ? '0 : r_pix_cnt + PW'(1);
                if (w_line_end) r_line_cnt <= r_line_cnt + LW'(1);
            end
        end
    end

`ifdef FRAME_WATCHDOG_EN
    localparam int WW = $clog2(WD_CYCLES + 1);
    logic [WW-1:0] r_wd_cnt;
    logic          r_error;

    assign w_wd_trip = w_active && !(w_in_beat || w_out_beat) && (r_wd_cnt == WW'(WD_CYCLES - 1));
    assign o_error   = r_error;

    // Any beat in either direction proves the frame is still moving.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_wd_cnt <= '0;
            r_error  <= 1'b0;
        end else if (w_start) begin
            r_wd_cnt <= '0;
            r_error  <= 1'b0;
        end else if (!w_active || w_in_beat || w_out_beat) begin
            r_wd_cnt <= '0;
        end else if (w_wd_trip) begin
            r_wd_cnt <= '0;
            r_error  <= 1'b1;
        end else begin
            r_wd_cnt <= r_wd_cnt + WW'(1);
        end
    end
`else
    assign w_wd_trip = 1'b0;
    assign o_error   = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer on an 8x6 frame: accepted pixels are queued and matched against the pipeline side.
module tb_frame_sequencer;
    logic       axi_clk = 1'b0;
    logic       axi_reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic [1:0] o_mode;
    logic       o_busy, o_done_intr, o_error;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_ready, m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic       i_line_intr = 1'b0;
    logic       i_out_valid = 1'b0;
    logic       i_out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int acc = 0;
    int done_seen = 0;
    logic [7:0] q[$];

    frame_sequencer #(.IMG_W(8), .IMG_H(6), .PRIME_LINES(4), .OUT_COUNT(48), .WD_CYCLES(100)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .i_start(i_start), .i_mode(i_mode),
        .o_mode(o_mode), .o_busy(o_busy), .o_done_intr(o_done_intr),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .i_line_intr(i_line_intr), .i_out_valid(i_out_valid), .i_out_ready(i_out_ready),
        .o_error(o_error)
    );

    always #5 axi_clk = ~axi_clk;

    // One cycle: drive at the falling edge, sample 1ns later, the beat lands on the next rising edge.
    task automatic cyc(input logic sv, input logic mr, input logic intr, input logic ov, input logic st);
        logic [7:0] e;
        @(negedge axi_clk);
        s_valid = sv; s_data = 8'($urandom_range(0, 255)); m_ready = mr;
        i_line_intr = intr; i_out_valid = ov; i_out_ready = 1'b1; i_start = st;
        #1;
        if (o_done_intr) done_seen++;
        if (s_valid && s_ready) begin
            q.push_back(s_data);
            acc++;
        end
        if (m_valid && m_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL m_beat_unexpected got %h required no beat", m_data);
            end else begin
                e = q.pop_front();
                if (m_data !== e) begin
                    n_err++;
                    $display("FAIL m_data got %h required %h", m_data, e);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge axi_clk);
        axi_reset_n = 1'b0; i_start = 1'b0; s_valid = 1'b0; i_line_intr = 1'b0; i_out_valid = 1'b0;
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        acc = 0;
        q.delete();
    endtask

    task automatic drain_out();
        int d0;
        d0 = done_seen;
        for (int k = 0; k < 48; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        n_vec++; if (done_seen != d0) begin n_err++; $display("FAIL done_early got %0d required %0d", done_seen, d0); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (o_done_intr !== 1'b1) begin n_err++; $display("FAIL done_pulse got %b required 1", o_done_intr); end
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL busy_in_done got %b required 1", o_busy); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (o_done_intr !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got %b required 0", o_done_intr); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL busy_after_done got %b required 0", o_busy); end
    endtask

    task automatic test_reset();
        s_valid = 1'b1; m_ready = 1'b1; i_start = 1'b0;
        #2;
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready got %b required 0", s_ready); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got %b required 0", m_valid); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b required 0", o_busy); end
        n_vec++; if (o_mode !== 2'd0) begin n_err++; $display("FAIL rst_mode got %0d required 0", o_mode); end
        n_vec++; if (o_done_intr !== 1'b0) begin n_err++; $display("FAIL rst_done got %b required 0", o_done_intr); end
        n_vec++; if (o_error !== 1'b0) begin n_err++; $display("FAIL rst_error got %b required 0", o_error); end
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL idle_s_ready got %b required 0", s_ready); end
    endtask

    task automatic test_credit_stall();
        acc = 0;
        i_mode = 2'd2;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 60; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (acc != 32) begin n_err++; $display("FAIL stall_beats got %0d required 32", acc); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL stall_s_ready got %b required 0", s_ready); end
        n_vec++; if (o_mode !== 2'd2) begin n_err++; $display("FAIL stall_mode got %0d required 2", o_mode); end
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL stall_busy got %b required 1", o_busy); end
    endtask

    task automatic test_refill_and_done();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20 && acc < 40; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (acc != 40) begin n_err++; $display("FAIL refill1_beats got %0d required 40", acc); end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20 && acc < 48; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++; if (acc != 48) begin n_err++; $display("FAIL refill2_beats got %0d required 48", acc); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL drain_s_ready got %b required 0", s_ready); end
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL drain_busy got %b required 1", o_busy); end
        drain_out();
    endtask

    task automatic test_same_cycle_intr();
        acc = 0;
        i_mode = 2'd3;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 80 && acc < 40; k++) cyc(1'b1, 1'b1, (acc == 7), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (acc != 40) begin n_err++; $display("FAIL same_cycle_beats got %0d required 40", acc); end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20 && acc < 48; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (acc != 48) begin n_err++; $display("FAIL same_cycle_total got %0d required 48", acc); end
        drain_out();
    endtask

    task automatic test_credit_ceiling();
        acc = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 50; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (acc != 32) begin n_err++; $display("FAIL ceiling_beats got %0d required 32", acc); end
        for (int k = 0; k < 40 && acc < 48; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++; if (acc != 48) begin n_err++; $display("FAIL ceiling_total got %0d required 48", acc); end
        drain_out();
    endtask

    task automatic test_mode_lock();
        acc = 0;
        i_mode = 2'd2;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 100 && acc < 48; k++) begin
            if (k == 20) i_mode = 2'd1;
            cyc(1'b1, 1'b1, 1'b1, 1'b1, (k == 20));
        end
        n_vec++; if (acc != 48) begin n_err++; $display("FAIL lock_beats got %0d required 48", acc); end
        n_vec++; if (o_mode !== 2'd2) begin n_err++; $display("FAIL lock_mode got %0d required 2", o_mode); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (o_done_intr !== 1'b0) begin n_err++; $display("FAIL feed_drain_exit got %b required 0", o_done_intr); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (o_done_intr !== 1'b1) begin n_err++; $display("FAIL feed_done_pulse got %b required 1", o_done_intr); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (o_mode !== 2'd2) begin n_err++; $display("FAIL idle_mode_hold got %0d required 2", o_mode); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL lock_idle_busy got %b required 0", o_busy); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (o_mode !== 2'd1) begin n_err++; $display("FAIL new_mode got %0d required 1", o_mode); end
    endtask

    task automatic test_random_ready();
        do_reset();
        i_mode = 2'd0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 400 && acc < 48; k++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (acc != 48) begin n_err++; $display("FAIL rand_beats got %0d required 48", acc); end
        n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rand_leftover got %0d required 0", q.size()); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rand_drain_m_valid got %b required 0", m_valid); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        i_mode = 2'd3;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 60 && acc < 28; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        axi_reset_n = 1'b0;
        #1;
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL async_s_ready got %b required 0", s_ready); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL async_busy got %b required 0", o_busy); end
        n_vec++; if (o_mode !== 2'd0) begin n_err++; $display("FAIL async_mode got %0d required 0", o_mode); end
        q.delete();
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        acc = 0;
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        n_vec++; if (acc != 0) begin n_err++; $display("FAIL post_reset_beats got %0d required 0", acc); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b required 0", o_busy); end
    endtask

    task automatic test_watchdog();
        do_reset();
        done_seen = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 60 && acc < 32; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 99; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (o_error !== 1'b0) begin n_err++; $display("FAIL wd_early got %b required 0", o_error); end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FRAME_WATCHDOG_EN
        n_vec++; if (o_error !== 1'b1) begin n_err++; $display("FAIL wd_error got %b required 1", o_error); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL wd_idle got %b required 0", o_busy); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL wd_gate got %b required 0", s_ready); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (o_error !== 1'b0) begin n_err++; $display("FAIL wd_clear got %b required 0", o_error); end
`else
        n_vec++; if (o_error !== 1'b0) begin n_err++; $display("FAIL no_wd_error got %b required 0", o_error); end
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL no_wd_busy got %b required 1", o_busy); end
`endif
        n_vec++; if (done_seen != 0) begin n_err++; $display("FAIL wd_no_done got %0d required 0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_credit_stall();
        test_refill_and_done();
        test_same_cycle_intr();
        test_credit_ceiling();
        test_mode_lock();
        test_random_ready();
        test_reset_midframe();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1);
    end
endmodule
